multi_cycle_ctrl: RTL and testbench

Control-unit state machine for the multi-cycle CPU. It sequences each instruction through IF/ID/EXE/MEM/WB, decodes the opcode held in the instruction register, and drives every datapath enable and mux select. That includes PCWre and PCSrc, which go straight into the program-counter stage. The PC stage updates only on the cycle this block raises PCWre.

---
 rtl/multi_cycle_ctrl_pkg.sv | 77 +++++++
 rtl/multi_cycle_ctrl_if.sv | 32 +++
 rtl/multi_cycle_ctrl_decode.sv | 99 +++++++++
 rtl/multi_cycle_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_multi_cycle_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control unit: opcodes, FSM states,
// datapath select codes and the instruction classes produced by the decoder.
package multi_cycle_ctrl_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLTI  = 6'b011100;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [3:0] {
        S_IF     = 4'b0000,
        S_ID     = 4'b0001,
        S_EXE_LS = 4'b0010,
        S_MEM    = 4'b0011,
        S_WB_LD  = 4'b0100,
        S_EXE_BR = 4'b0101,
        S_EXE_AL = 4'b0110,
        S_WB_AL  = 4'b0111,
        S_HALT   = 4'b1000
    } state_e;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b110;

    localparam logic [1:0] PCSRC_NEXT   = 2'd0;
    localparam logic [1:0] PCSRC_BRANCH = 2'd1;
    localparam logic [1:0] PCSRC_JR     = 2'd2;
    localparam logic [1:0] PCSRC_JUMP   = 2'd3;

    localparam logic [1:0] REGDST_RA = 2'b00;
    localparam logic [1:0] REGDST_RT = 2'b01;
    localparam logic [1:0] REGDST_RD = 2'b10;

    typedef enum logic [2:0] {
        CLS_UNDEF  = 3'd0,
        CLS_ALU    = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JUMP   = 3'd5,
        CLS_HALT   = 3'd6
    } instr_class_e;

    // Branch condition from the ALU flags; non-branch opcodes never take.
    function automatic logic branch_taken(input logic [5:0] op,
                                          input logic zero,
                                          input logic sign);
        logic taken;
        case (op)
            OP_BEQ:  taken = zero;
            OP_BNE:  taken = ~zero;
            OP_BLTZ: taken = sign;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control bundle between the control unit (master) and the datapath (slave).
interface multi_cycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       sign;
    logic [3:0] state;
    logic       pc_wre;
    logic [1:0] pc_src;
    logic       ir_wre;
    logic       reg_wre;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       m_rd;
    logic       m_wr;
    logic       db_data_src;

    modport master (
        input  opcode, zero, sign,
        output state, pc_wre, pc_src, ir_wre, reg_wre, reg_dst, wr_reg_d_src,
               alu_src_a, alu_src_b, alu_op, ext_sel, m_rd, m_wr, db_data_src
    );

    modport slave (
        output opcode, zero, sign,
        input  state, pc_wre, pc_src, ir_wre, reg_wre, reg_dst, wr_reg_d_src,
               alu_src_a, alu_src_b, alu_op, ext_sel, m_rd, m_wr, db_data_src
    );
endinterface

// File: rtl/multi_cycle_ctrl_decode.sv
// Pure combinational opcode decoder: instruction class plus the static
// datapath fields that do not depend on the FSM state.
module ctrl_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [5:0]   i_opcode,
    output instr_class_e o_class,
    output logic [2:0]   o_alu_op,
    output logic         o_ext_sel,
    output logic         o_alu_src_a,
    output logic         o_alu_src_b,
    output logic [1:0]   o_reg_dst
);

    // Opcode to class and static fields; unknown opcodes fall to CLS_UNDEF.
    always_comb begin
        o_class     = CLS_UNDEF;
        o_alu_op    = ALU_ADD;
        o_ext_sel   = 1'b1;
        o_alu_src_a = 1'b0;
        o_alu_src_b = 1'b0;
        o_reg_dst   = REGDST_RT;
        case (i_opcode)
            OP_ADD: begin
                o_class   = CLS_ALU;
                o_reg_dst = REGDST_RD;
            end
            OP_SUB: begin
                o_class   = CLS_ALU;
                o_alu_op  = ALU_SUB;
                o_reg_dst = REGDST_RD;
            end
            OP_ADDIU: begin
                o_class     = CLS_ALU;
                o_alu_src_b = 1'b1;
            end
            OP_AND: begin
                o_class   = CLS_ALU;
                o_alu_op  = ALU_AND;
                o_reg_dst = REGDST_RD;
            end
            OP_ANDI: begin
                o_class     = CLS_ALU;
                o_alu_op    = ALU_AND;
                o_ext_sel   = 1'b0;
                o_alu_src_b = 1'b1;
            end
            OP_ORI: begin
                o_class     = CLS_ALU;
                o_alu_op    = ALU_OR;
                o_ext_sel   = 1'b0;
                o_alu_src_b = 1'b1;
            end
            OP_XORI: begin
                o_class     = CLS_ALU;
                o_alu_op    = ALU_XOR;
                o_ext_sel   = 1'b0;
                o_alu_src_b = 1'b1;
            end
            OP_SLL: begin
                o_class     = CLS_ALU;
                o_alu_op    = ALU_SLL;
                o_alu_src_a = 1'b1;
                o_reg_dst   = REGDST_RD;
            end
            OP_SLTI: begin
                o_class     = CLS_ALU;
                o_alu_op    = ALU_SLT;
                o_alu_src_b = 1'b1;
            end
            OP_SW: begin
                o_class     = CLS_STORE;
                o_alu_src_b = 1'b1;
            end
            OP_LW: begin
                o_class     = CLS_LOAD;
                o_alu_src_b = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLTZ: begin
                o_class  = CLS_BRANCH;
                o_alu_op = ALU_SUB;
            end
            OP_J, OP_JR: begin
                o_class = CLS_JUMP;
            end
            OP_JAL: begin
                o_class   = CLS_JUMP;
                o_reg_dst = REGDST_RA;
            end
            OP_HALT: begin
                o_class = CLS_HALT;
            end
            default: begin
                o_class = CLS_UNDEF;
            end
        endcase
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EXE/MEM/WB and gates the
// datapath enables per state. Outputs are combinational from the state register.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    multi_cycle_ctrl_if.master    bus
);

    state_e       r_state;
    state_e       w_next_state;
    instr_class_e w_class;
    logic [2:0]   w_dec_alu_op;
    logic         w_dec_ext_sel;
    logic         w_dec_alu_src_a;
    logic         w_dec_alu_src_b;
    logic [1:0]   w_dec_reg_dst;

    logic         w_pc_wre;
    logic [1:0]   w_pc_src;
    logic         w_ir_wre;
    logic         w_reg_wre;
    logic [1:0]   w_reg_dst;
    logic         w_wr_reg_d_src;
    logic         w_alu_src_a;
    logic         w_alu_src_b;
    logic [2:0]   w_alu_op;
    logic         w_ext_sel;
    logic         w_m_rd;
    logic         w_m_wr;
    logic         w_db_data_src;

    ctrl_decode u_decode (
        .i_opcode    (bus.opcode),
        .o_class     (w_class),
        .o_alu_op    (w_dec_alu_op),
        .o_ext_sel   (w_dec_ext_sel),
        .o_alu_src_a (w_dec_alu_src_a),
        .o_alu_src_b (w_dec_alu_src_b),
        .o_reg_dst   (w_dec_reg_dst)
    );

    // Next-state selection from the current state and decoded class.
    always_comb begin
        w_next_state = S_IF;
        case (r_state)
            S_IF: w_next_state = S_ID;
            S_ID: begin
                case (w_class)
                    CLS_JUMP:   w_next_state = S_IF;
                    CLS_HALT:   w_next_state = S_HALT;
                    CLS_BRANCH: w_next_state = S_EXE_BR;
                    CLS_LOAD:   w_next_state = S_EXE_LS;
                    CLS_STORE:  w_next_state = S_EXE_LS;
                    CLS_ALU:    w_next_state = S_EXE_AL;
                    default:    w_next_state = S_IF;
                endcase
            end
            S_EXE_AL: w_next_state = S_WB_AL;
            S_WB_AL:  w_next_state = S_IF;
            S_EXE_BR: w_next_state = S_IF;
            S_EXE_LS: w_next_state = S_MEM;
            S_MEM: begin
                if (w_class == CLS_LOAD) begin
                    w_next_state = S_WB_LD;
                end else begin
                    w_next_state = S_IF;
                end
            end
            S_WB_LD: w_next_state = S_IF;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IF;
        endcase
    end

    // State register; the only storage in the block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Per-state enable gating; static decode fields apply outside sIF.
    always_comb begin
        w_pc_wre       = 1'b0;
        w_pc_src       = PCSRC_NEXT;
        w_ir_wre       = 1'b0;
        w_reg_wre      = 1'b0;
        w_reg_dst      = 2'b00;
        w_wr_reg_d_src = 1'b0;
        w_m_rd         = 1'b0;
        w_m_wr         = 1'b0;
        w_db_data_src  = 1'b0;

        if (r_state != S_IF) begin
            w_alu_op    = w_dec_alu_op;
            w_ext_sel   = w_dec_ext_sel;
            w_alu_src_a = w_dec_alu_src_a;
            w_alu_src_b = w_dec_alu_src_b;
        end else begin
            w_alu_op    = 3'b000;
            w_ext_sel   = 1'b0;
            w_alu_src_a = 1'b0;
            w_alu_src_b = 1'b0;
        end

        case (r_state)
            S_IF: w_ir_wre = 1'b1;
            S_ID: begin
                if (w_class == CLS_JUMP) begin
                    w_pc_wre = 1'b1;
                    w_pc_src = (bus.opcode == OP_JR) ? PCSRC_JR : PCSRC_JUMP;
                    if (bus.opcode == OP_JAL) begin
                        w_reg_wre      = 1'b1;
                        w_reg_dst      = REGDST_RA;
                        w_wr_reg_d_src = 1'b0;
                    end else begin
                        w_reg_wre = 1'b0;
                    end
                end else if (w_class == CLS_UNDEF) begin
                    // Unknown opcode retires as a NOP straight from decode.
                    w_pc_wre = 1'b1;
                    w_pc_src = PCSRC_NEXT;
                end else begin
                    w_pc_wre = 1'b0;
                end
            end
            S_EXE_BR: begin
                w_pc_wre = 1'b1;
                w_pc_src = branch_taken(bus.opcode, bus.zero, bus.sign) ?
                           PCSRC_BRANCH : PCSRC_NEXT;
            end
            S_WB_AL: begin
                w_reg_wre      = 1'b1;
                w_wr_reg_d_src = 1'b1;
                w_reg_dst      = w_dec_reg_dst;
                w_pc_wre       = 1'b1;
            end
            S_MEM: begin
                if (w_class == CLS_STORE) begin
                    w_m_wr   = 1'b1;
                    w_pc_wre = 1'b1;
                end else if (w_class == CLS_LOAD) begin
                    w_m_rd = 1'b1;
                end else begin
                    w_pc_wre = 1'b0;
                end
            end
            S_WB_LD: begin
                w_m_rd         = 1'b1;
                w_db_data_src  = 1'b1;
                w_reg_wre      = 1'b1;
                w_reg_dst      = REGDST_RT;
                w_wr_reg_d_src = 1'b1;
                w_pc_wre       = 1'b1;
            end
            default: begin
                w_pc_wre = 1'b0;
            end
        endcase
    end

    // Reset low kills every output asynchronously, independent of the clock.
    assign bus.state        = i_rst_n ? r_state        : 4'b0000;
    assign bus.pc_wre       = i_rst_n & w_pc_wre;
    assign bus.pc_src       = i_rst_n ? w_pc_src       : 2'b00;
    assign bus.ir_wre       = i_rst_n & w_ir_wre;
    assign bus.reg_wre      = i_rst_n & w_reg_wre;
    assign bus.reg_dst      = i_rst_n ? w_reg_dst      : 2'b00;
    assign bus.wr_reg_d_src = i_rst_n & w_wr_reg_d_src;
    assign bus.alu_src_a    = i_rst_n & w_alu_src_a;
    assign bus.alu_src_b    = i_rst_n & w_alu_src_b;
    assign bus.alu_op       = i_rst_n ? w_alu_op       : 3'b000;
    assign bus.ext_sel      = i_rst_n & w_ext_sel;
    assign bus.m_rd         = i_rst_n & w_m_rd;
    assign bus.m_wr         = i_rst_n & w_m_wr;
    assign bus.db_data_src  = i_rst_n & w_db_data_src;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed bench for multi_cycle_ctrl: steps each instruction class through
// its states and checks state plus the full control vector every cycle.
module tb_multi_cycle_ctrl;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    multi_cycle_ctrl_if bus ();

    multi_cycle_ctrl dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: pcwre pcsrc irwre regwre regdst wrsrc srca srcb aluop ext mrd mwr dbsrc
    function automatic logic [16:0] cv(input logic pcw, input logic [1:0] pcs,
                                       input logic irw, input logic regw,
                                       input logic [1:0] rd, input logic wds,
                                       input logic asa, input logic asb,
                                       input logic [2:0] op, input logic ext,
                                       input logic mrd, input logic mwr,
                                       input logic dbs);
        return {pcw, pcs, irw, regw, rd, wds, asa, asb, op, ext, mrd, mwr, dbs};
    endfunction

    task automatic chk(input string tag, input logic [3:0] st, input logic [16:0] v);
        logic [16:0] obs;
        obs = {bus.pc_wre, bus.pc_src, bus.ir_wre, bus.reg_wre, bus.reg_dst,
               bus.wr_reg_d_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
               bus.ext_sel, bus.m_rd, bus.m_wr, bus.db_data_src};
        checks++;
        assert ({bus.state, obs} === {st, v}) else begin
            errors++;
            $error("FAIL %s: observed state=%b ctl=%b expected state=%b ctl=%b",
                   tag, bus.state, obs, st, v);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] st, input logic [16:0] v);
        @(posedge clk);
        @(negedge clk);
        chk(tag, st, v);
    endtask

    initial begin
        logic [16:0] v_if;
        logic [16:0] v_zero;
        errors = 0;
        checks = 0;
        v_if   = cv(1'b0, 2'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        v_zero = 17'd0;

        rst_n      = 1'b0;
        bus.opcode = 6'b000000;
        bus.zero   = 1'b0;
        bus.sign   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset", 4'b0000, v_zero);
        rst_n = 1'b1;
        #1 chk("if_after_rst", 4'b0000, v_if);

        // add: IF ID EXE_AL WB_AL
        bus.opcode = 6'b000000;
        step("add_id",  4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("add_exe", 4'b0110, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("add_wb",  4'b0111, cv(1'b1, 2'd0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("add_next_if", 4'b0000, v_if);

        // xori: zero-extended immediate, RegDst=rt
        bus.opcode = 6'b010011;
        step("xori_id",  4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0));
        step("xori_exe", 4'b0110, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0));
        step("xori_wb",  4'b0111, cv(1'b1, 2'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0));
        step("xori_next_if", 4'b0000, v_if);

        // sll: shamt on A, RegDst=rd
        bus.opcode = 6'b011000;
        step("sll_id",  4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sll_exe", 4'b0110, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sll_wb",  4'b0111, cv(1'b1, 2'd0, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sll_next_if", 4'b0000, v_if);

        // lw: five states, mRD in MEM and WB_LD
        bus.opcode = 6'b110001;
        step("lw_id",  4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("lw_exe", 4'b0010, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("lw_mem", 4'b0011, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b0));
        step("lw_wb",  4'b0100, cv(1'b1, 2'd0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1));
        step("lw_next_if", 4'b0000, v_if);

        // beq taken then not taken
        bus.opcode = 6'b110100;
        bus.zero   = 1'b1;
        step("beq_t_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("beq_t_br", 4'b0101, cv(1'b1, 2'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("beq_t_if", 4'b0000, v_if);
        bus.zero = 1'b0;
        step("beq_n_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("beq_n_br", 4'b0101, cv(1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("beq_n_if", 4'b0000, v_if);

        // bne: taken on zero=0
        bus.opcode = 6'b110101;
        bus.zero   = 1'b0;
        step("bne_t_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("bne_t_br", 4'b0101, cv(1'b1, 2'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("bne_t_if", 4'b0000, v_if);
        bus.zero = 1'b1;
        step("bne_n_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("bne_n_br", 4'b0101, cv(1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("bne_n_if", 4'b0000, v_if);

        // bltz: taken on sign=1 regardless of zero
        bus.opcode = 6'b110110;
        bus.zero   = 1'b0;
        bus.sign   = 1'b1;
        step("bltz_t_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("bltz_t_br", 4'b0101, cv(1'b1, 2'd1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("bltz_t_if", 4'b0000, v_if);
        bus.sign = 1'b0;
        bus.zero = 1'b1;
        step("bltz_n_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("bltz_n_br", 4'b0101, cv(1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0));
        step("bltz_n_if", 4'b0000, v_if);
        bus.zero = 1'b0;

        // jal, jr, j: two cycles each
        bus.opcode = 6'b111010;
        step("jal_id", 4'b0001, cv(1'b1, 2'd3, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("jal_if", 4'b0000, v_if);
        bus.opcode = 6'b111001;
        step("jr_id",  4'b0001, cv(1'b1, 2'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("jr_if",  4'b0000, v_if);
        bus.opcode = 6'b111000;
        step("j_id",   4'b0001, cv(1'b1, 2'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("j_if",   4'b0000, v_if);

        // undefined opcode retires as NOP from decode
        bus.opcode = 6'b000111;
        step("undef_id", 4'b0001, cv(1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("undef_if", 4'b0000, v_if);

        // sw with reset asserted mid-sMEM
        bus.opcode = 6'b110000;
        step("sw_id",  4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sw_exe", 4'b0010, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sw_mem", 4'b0011, cv(1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0));
        rst_n = 1'b0;
        #1 chk("sw_async_rst", 4'b0000, v_zero);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("sw_rst_release", 4'b0000, v_if);
        step("sw_restart_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sw_restart_exe", 4'b0010, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        step("sw_restart_mem", 4'b0011, cv(1'b1, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0));
        step("sw_next_if", 4'b0000, v_if);

        // halt: parks in sHALT until reset
        bus.opcode = 6'b111111;
        step("halt_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 20; i++) begin
            step("halt_hold", 4'b1000, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        rst_n = 1'b0;
        #1 chk("halt_rst", 4'b0000, v_zero);
        @(negedge clk);
        rst_n = 1'b1;
        bus.opcode = 6'b000000;
        #1 chk("halt_recover_if", 4'b0000, v_if);
        step("halt_recover_id", 4'b0001, cv(1'b0, 2'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
